// File: rtl/ram_port_arbiter.sv
// Shares the single byte-wide RAM/IO bus between the instruction-fetch path and the MEM stage.
// Multi-byte transfers are sequenced little-endian, one byte per cycle. Read data arrives the
// cycle after its address. Fetches can be aborted by a branch flush. IO writes stall while the
// UART TX buffer is full.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter bit          DATA_PRIORITY = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              inst_req_in,
  input  logic [ADDR_W-1:0] inst_addr_in,
  input  logic              flush_in,
  input  logic              data_req_in,
  input  logic              data_we_in,
  input  logic [2:0]        data_width_in,
  input  logic [ADDR_W-1:0] data_addr_in,
  input  logic [31:0]       data_wdata_in,
  input  logic              io_buffer_full_in,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  output logic              inst_done_out,
  output logic [31:0]       inst_data_out,
  output logic              data_done_out,
  output logic [31:0]       data_rdata_out,
  output logic              inst_busy_out,
  output logic              data_busy_out
);

  typedef enum logic [2:0] {StIdle, StInstRd, StDataRd, StDataWr, StResp} state_e;

  state_e r_state, w_state_d;

  // Transfer bookkeeping. In read states r_cnt is the cycle index within the transfer. In
  // DATA_WR it is the index of the next byte to issue.
  logic [2:0]        r_cnt, w_cnt_d;
  logic [2:0]        r_len, w_len_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [31:0]       r_wdata, w_wdata_d;
  logic [31:0]       r_rbuf, w_rbuf_d;
  logic              r_tie_data, w_tie_data_d;

  // Registered outputs and their next values.
  logic [ADDR_W-1:0] r_ram_a, w_ram_a_d;
  logic [7:0]        r_ram_dout, w_ram_dout_d;
  logic              r_ram_wr, w_ram_wr_d;
  logic              r_inst_done, w_inst_done_d;
  logic [31:0]       r_inst_data, w_inst_data_d;
  logic              r_data_done, w_data_done_d;
  logic [31:0]       r_data_rdata, w_data_rdata_d;
  logic              r_busy, w_busy_d;

  // Decode helpers.
  logic [2:0]        w_data_len;
  logic              w_inst_ok;
  logic              w_tie;
  logic              w_grant_data;
  logic              w_grant_inst;
  logic              w_last_rd;
  logic              w_last_wr;
  logic [ADDR_W-1:0] w_cur_addr;
  logic              w_wr_blocked;
  logic [31:0]       w_rd_merge;
  logic [7:0]        w_wr_byte;

  // Widths of 0 or above 4 mean a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] w);
    return ((w == 3'd0) || (w > 3'd4)) ? 3'd4 : w;
  endfunction

  // Request arbitration and per-cycle transfer decode.
  always_comb begin
    w_data_len   = norm_len(data_width_in);
    w_inst_ok    = inst_req_in && !flush_in;
    w_tie        = data_req_in && w_inst_ok;
    w_grant_data = data_req_in && (!w_inst_ok || DATA_PRIORITY || r_tie_data);
    w_grant_inst = w_inst_ok && !w_grant_data;
    // The last read byte is captured one cycle after its address was issued.
    w_last_rd    = (r_cnt == (r_len + 3'd1));
    w_last_wr    = (r_cnt == r_len);
    w_cur_addr   = (r_state == StIdle) ? data_addr_in : (r_addr + ADDR_W'(r_cnt));
    w_wr_blocked = io_buffer_full_in && (w_cur_addr[17:16] == 2'b11);

    // Byte r_cnt-2 is on ram_din_in this cycle.
    w_rd_merge = r_rbuf;
    case (r_cnt)
      3'd2:    w_rd_merge[7:0]   = ram_din_in;
      3'd3:    w_rd_merge[15:8]  = ram_din_in;
      3'd4:    w_rd_merge[23:16] = ram_din_in;
      3'd5:    w_rd_merge[31:24] = ram_din_in;
      default: ;
    endcase

    case (r_cnt)
      3'd1:    w_wr_byte = r_wdata[15:8];
      3'd2:    w_wr_byte = r_wdata[23:16];
      3'd3:    w_wr_byte = r_wdata[31:24];
      default: w_wr_byte = r_wdata[7:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_grant_data) begin
          w_state_d = data_we_in ? StDataWr : StDataRd;
        end else if (w_grant_inst) begin
          w_state_d = StInstRd;
        end
      end
      StInstRd: begin
        if (flush_in) begin
          w_state_d = StIdle;
        end else if (w_last_rd) begin
          w_state_d = StResp;
        end
      end
      StDataRd: begin
        if (w_last_rd) begin
          w_state_d = StResp;
        end
      end
      StDataWr: begin
        if (w_last_wr) begin
          w_state_d = StResp;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output and datapath next values; bus signals default to idle each cycle.
  always_comb begin
    w_cnt_d        = r_cnt;
    w_len_d        = r_len;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_rbuf_d       = r_rbuf;
    w_tie_data_d   = r_tie_data;
    w_ram_a_d      = '0;
    w_ram_dout_d   = 8'h00;
    w_ram_wr_d     = 1'b0;
    w_inst_done_d  = 1'b0;
    w_data_done_d  = 1'b0;
    w_inst_data_d  = r_inst_data;
    w_data_rdata_d = r_data_rdata;
    w_busy_d       = (w_state_d != StIdle);

    case (r_state)
      StIdle: begin
        if (w_tie && !DATA_PRIORITY) begin
          w_tie_data_d = !r_tie_data;
        end
        if (w_grant_data) begin
          w_addr_d  = data_addr_in;
          w_len_d   = w_data_len;
          w_wdata_d = data_wdata_in;
          w_rbuf_d  = '0;
          w_ram_a_d = data_addr_in;
          if (!data_we_in) begin
            w_cnt_d = 3'd1;
          end else if (w_wr_blocked) begin
            w_cnt_d = 3'd0;
          end else begin
            w_ram_dout_d = data_wdata_in[7:0];
            w_ram_wr_d   = 1'b1;
            w_cnt_d      = 3'd1;
          end
        end else if (w_grant_inst) begin
          w_addr_d  = inst_addr_in;
          w_len_d   = 3'd4;
          w_rbuf_d  = '0;
          w_ram_a_d = inst_addr_in;
          w_cnt_d   = 3'd1;
        end
      end
      StInstRd, StDataRd: begin
        w_rbuf_d = w_rd_merge;
        if ((r_state == StInstRd) && flush_in) begin
          // Abort: bytes still in flight are dropped with the rest of the transfer.
          w_cnt_d = 3'd0;
        end else if (w_last_rd) begin
          w_cnt_d = 3'd0;
          if (r_state == StInstRd) begin
            w_inst_done_d = 1'b1;
            w_inst_data_d = w_rd_merge;
          end else begin
            w_data_done_d  = 1'b1;
            w_data_rdata_d = w_rd_merge;
          end
        end else begin
          w_cnt_d = r_cnt + 3'd1;
          if (r_cnt < r_len) begin
            w_ram_a_d = r_addr + ADDR_W'(r_cnt);
          end
        end
      end
      StDataWr: begin
        if (w_last_wr) begin
          w_cnt_d       = 3'd0;
          w_data_done_d = 1'b1;
        end else if (w_wr_blocked) begin
          // Hold the pending byte address with the strobe low until the UART drains.
          w_ram_a_d = w_cur_addr;
        end else begin
          w_ram_a_d    = w_cur_addr;
          w_ram_dout_d = w_wr_byte;
          w_ram_wr_d   = 1'b1;
          w_cnt_d      = r_cnt + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt        <= 3'd0;
      r_len        <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rbuf       <= '0;
      r_tie_data   <= 1'b1;
      r_ram_a      <= '0;
      r_ram_dout   <= 8'h00;
      r_ram_wr     <= 1'b0;
      r_inst_done  <= 1'b0;
      r_inst_data  <= '0;
      r_data_done  <= 1'b0;
      r_data_rdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_len        <= w_len_d;
      r_addr       <= w_addr_d;
      r_wdata      <= w_wdata_d;
      r_rbuf       <= w_rbuf_d;
      r_tie_data   <= w_tie_data_d;
      r_ram_a      <= w_ram_a_d;
      r_ram_dout   <= w_ram_dout_d;
      r_ram_wr     <= w_ram_wr_d;
      r_inst_done  <= w_inst_done_d;
      r_inst_data  <= w_inst_data_d;
      r_data_done  <= w_data_done_d;
      r_data_rdata <= w_data_rdata_d;
      r_busy       <= w_busy_d;
    end
  end

  assign ram_a_out      = r_ram_a;
  assign ram_dout_out   = r_ram_dout;
  assign ram_wr_out     = r_ram_wr;
  assign inst_done_out  = r_inst_done;
  assign inst_data_out  = r_inst_data;
  assign data_done_out  = r_data_done;
  assign data_rdata_out = r_data_rdata;
  assign inst_busy_out  = r_busy;
  assign data_busy_out  = r_busy;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 8-bit RAM/IO bus (one byte per cycle, read data returned the following cycle) between two requesters: the instruction-fetch path (icache miss, 32-bit reads) and the MEM stage (1/2/4-byte loads and stores).
- Sequences multi-byte transfers little-endian, owns the bus drive signals, and handles three special cases: branch-flush abort of fetches, UART-full back-pressure on IO writes, and tie arbitration.
- Sits between the icache/MEM stage and the top-level mem_a/mem_dout/mem_wr pins.

Parameters:
ADDR_W, 32, width of request addresses and of ram_a_out
DATA_PRIORITY, 1, 1: data wins every tie in IDLE; 0: ties alternate, starting with data after reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
inst_req_in  input  1  fetch request, level-held until inst_done_out or flush
inst_addr_in  input  ADDR_W  fetch byte address, stable while inst_req_in high
flush_in  input  1  branch taken; abort or refuse fetch
data_req_in  input  1  MEM request, level-held until data_done_out
data_we_in  input  1  1 store, 0 load
data_width_in  input  3  byte count 1/2/4
data_addr_in  input  ADDR_W  data byte address
data_wdata_in  input  32  store data, byte0 = bits 7:0
io_buffer_full_in  input  1  UART TX buffer full
ram_din_in  input  8  RAM read byte
ram_dout_out  output  8  RAM write byte
ram_a_out  output  ADDR_W  RAM address
ram_wr_out  output  1  1 = write
inst_done_out  output  1  one-cycle fetch completion pulse
inst_data_out  output  32  fetched word, valid with inst_done_out, held until the next fetch completes
data_done_out  output  1  one-cycle MEM completion pulse
data_rdata_out  output  32  load data, zero-extended above width, held until the next load completes
inst_busy_out  output  1  bus not available to fetch (state != IDLE)
data_busy_out  output  1  bus not available to MEM (state != IDLE)

Behaviour:
- Every output is registered. Reset values: ram_a_out=0, ram_dout_out=0, ram_wr_out=0, done pulses=0, data outputs=0, busy=0. State resets to IDLE, byte counter to 0, tie-toggle to "data next".
- Reset mid-transfer aborts immediately. No done pulse is generated and partial data is discarded.
- States:
  - IDLE: evaluates requests.
  - INST_RD, DATA_RD, DATA_WR: transfer states.
  - RESP: done pulse for one cycle, then unconditionally IDLE. All requests are ignored in RESP, so a still-held req is not re-accepted.
- IDLE grant rules:
  - data_req only -> DATA_RD or DATA_WR.
  - inst_req && !flush_in only -> INST_RD.
  - Both: data wins if DATA_PRIORITY=1; otherwise the tie-toggle decides and flips after each tie grant.
  - inst_req with flush_in high in the same cycle is not granted.
- Address and data are latched at the grant edge (E0). Later changes to the request inputs are ignored until RESP.
- Width handling: a width of 0 or greater than 4 is treated as 4. A width of 3 is legal (3 bytes).
- Read timing (N bytes):
  - ram_a_out = addr+k during cycle k+1, for k = 0..N-1.
  - Byte k is captured from ram_din_in at edge E(k+2).
  - The done pulse is high in cycle N+2; a fetch therefore completes in cycle 6.
  - ram_a_out returns to 0 in RESP.
- Write timing (N bytes):
  - In cycle k+1: ram_a_out = addr+k, ram_dout_out = wdata byte k, ram_wr_out = 1.
  - data_done_out is high in cycle N+1.
- IO back-pressure: if a write targets addr[17:16]==2'b11 while io_buffer_full_in is high, the FSM holds in DATA_WR with ram_wr_out=0 and the byte counter frozen. The write resumes the cycle after full deasserts, so each byte is written exactly once.
- Flush during INST_RD: the next state is IDLE, ram_wr_out stays 0, inst_done_out is not pulsed, and inst_data_out keeps its old value. Late read bytes still returning on ram_din_in are ignored.
- flush_in has no effect on DATA_RD, DATA_WR or RESP.
- A request dropped early without flush: the transfer still completes and the done pulse is still issued.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- Fetch 0x00000100, RAM bytes 13,05,00,00 -> ram_a 0x100..0x103 in cycles 1-4; inst_done high in cycle 6 only; inst_data_out=0x00000513.
- Store word 0xDEADBEEF to 0x1000 -> cycles 1-4 drive wr=1 with (0x1000,EF),(0x1001,BE),(0x1002,AD),(0x1003,DE); data_done in cycle 5.
- inst_req and data_req (load, width 2, 0x2000, bytes 34,12) both raised in IDLE, DATA_PRIORITY=1 -> data granted first, data_rdata_out=0x00001234 with done in cycle 4; fetch is granted in the IDLE cycle after RESP.
- Byte store 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 for those 3 cycles, then exactly one write of 0x41 to 0x30000, followed by done.
- Fetch aborted by flush_in in cycle 3 -> no inst_done, FSM in IDLE at cycle 4; a new fetch to 0x200 then completes normally. Separately, rst_in pulsed mid-store -> all outputs 0 the next cycle and no done pulse.
